// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline register with a 2-entry skid buffer.
// Ports: clk, rstn (sync, active-low), flush, in_valid/in_ready/in_data/in_ctrl,
//        out_valid/out_ready/out_data/out_ctrl, occupancy;
//        `PIPE_STAGE_PERF_EN adds stall_cnt and bubble_cnt.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;

  logic in_fire;
  logic out_fire;
  logic st_empty;
  logic st_one;
  logic st_two;

  // Ready comes straight from a flop: no comb path from out_ready.
  assign in_ready  = ~s_valid_q;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign out_ctrl  = m_valid_q ? m_ctrl_q : '0;
  assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_valid_q & out_ready;

  assign st_empty = ~m_valid_q & ~s_valid_q;
  assign st_one   =  m_valid_q & ~s_valid_q;
  assign st_two   =  m_valid_q &  s_valid_q;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ctrl_d  = m_ctrl_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_ctrl_d  = s_ctrl_q;
    if (flush) begin
      m_valid_d = 1'b0;
      m_data_d  = '0;
      m_ctrl_d  = '0;
      s_valid_d = 1'b0;
      s_data_d  = '0;
      s_ctrl_d  = '0;
    end else begin
      unique case (1'b1)
        st_empty: begin
          if (in_fire) begin
            m_valid_d = 1'b1;
            m_data_d  = in_data;
            m_ctrl_d  = in_ctrl;
          end
        end
        st_one: begin
          if (in_fire && out_fire) begin
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
          end else if (in_fire) begin
            s_valid_d = 1'b1;
            s_data_d  = in_data;
            s_ctrl_d  = in_ctrl;
          end else if (out_fire) begin
            m_valid_d = 1'b0;
            m_data_d  = '0;
            m_ctrl_d  = '0;
          end
        end
        st_two: begin
          if (out_fire) begin
            m_data_d  = s_data_q;
            m_ctrl_d  = s_ctrl_q;
            s_valid_d = 1'b0;
            s_data_d  = '0;
            s_ctrl_d  = '0;
          end
        end
        default: begin
          // Skid valid without main valid is unreachable; recover to empty.
          m_valid_d = 1'b0;
          m_data_d  = '0;
          m_ctrl_d  = '0;
          s_valid_d = 1'b0;
          s_data_d  = '0;
          s_ctrl_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ctrl_q  <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      s_ctrl_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ctrl_q  <= m_ctrl_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_ctrl_q  <= s_ctrl_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating; flush does not clear them.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (m_valid_q && !out_ready && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (!m_valid_q && !(&bubble_cnt_q))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg.
// Inputs change #1 after posedge; outputs sampled at negedge or #1 after posedge.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int NW = 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } ent_t;

  logic          clk;
  logic          rstn;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [NW-1:0] stall_cnt;
  logic [NW-1:0] bubble_cnt;
  logic [NW-1:0] m_stall;
  logic [NW-1:0] m_bubble;
  logic [NW-1:0] st0;
  logic [NW-1:0] bb0;
`endif

  int n_chk;
  int n_err;
  ent_t sb[$];

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] ctl_of(input logic [DW-1:0] d);
    return d[CW-1:0] ^ 16'h5A5A;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = ctl_of(d);
  endtask

  // Scoreboard: pop on out_fire, push on accepted in_fire.
  always @(negedge clk) begin
    if (!rstn) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", {32'h0, out_data}, 64'hFFFF_FFFF);
        end else begin
          ent_t e;
          e = sb.pop_front();
          check("sb_data", {32'h0, out_data}, {32'h0, e.data});
          check("sb_ctrl", {48'h0, out_ctrl}, {48'h0, e.ctrl});
        end
      end
      if (flush)
        sb.delete();
      else if (in_valid && in_ready)
        sb.push_back('{data: in_data, ctrl: in_ctrl});
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  always @(negedge clk) begin
    if (!rstn) begin
      m_stall  <= '0;
      m_bubble <= '0;
    end else begin
      if (out_valid && !out_ready) m_stall <= m_stall + 1;
      if (!out_valid) m_bubble <= m_bubble + 1;
    end
  end
`endif

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rstn      = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEADBEEF;
    in_ctrl   = 16'hFFFF;

    // Reset with valid input present
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rst_ov", {63'h0, out_valid}, 64'h0);
      check("rst_oc", {48'h0, out_ctrl}, 64'h0);
      check("rst_occ", {62'h0, occupancy}, 64'h0);
      check("rst_ir", {63'h0, in_ready}, 64'h1);
    end
    rstn = 1'b1;
    drive(1'b0, '0);
    cyc();
    check("rst_nocap", {63'h0, out_valid}, 64'h0);
    check("rst_od", {32'h0, out_data}, 64'h0);

    // Streaming
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h100 + i);
      cyc();
      check("str_ov", {63'h0, out_valid}, 64'h1);
      check("str_od", {32'h0, out_data}, 64'h100 + i);
      check("str_ir", {63'h0, in_ready}, 64'h1);
      check("str_occ", {62'h0, occupancy}, 64'h1);
    end
    drive(1'b0, '0);
    cyc();
    check("str_drain", {62'h0, occupancy}, 64'h0);

    // Backpressure
    out_ready = 1'b0;
    drive(1'b1, 32'h11);
    cyc();
    check("bp_occ1", {62'h0, occupancy}, 64'h1);
    drive(1'b1, 32'h22);
    cyc();
    drive(1'b0, '0);
    check("bp_occ2", {62'h0, occupancy}, 64'h2);
    check("bp_ir0", {63'h0, in_ready}, 64'h0);
    check("bp_od", {32'h0, out_data}, 64'h11);
    cyc();
    check("bp_hold_d", {32'h0, out_data}, 64'h11);
    check("bp_hold_c", {48'h0, out_ctrl}, {48'h0, ctl_of(32'h11)});
    out_ready = 1'b1;
    cyc();
    check("bp_od2", {32'h0, out_data}, 64'h22);
    check("bp_ir1", {63'h0, in_ready}, 64'h1);
    check("bp_occ_a", {62'h0, occupancy}, 64'h1);
    cyc();
    check("bp_empty", {63'h0, out_valid}, 64'h0);

    // Flush with two entries and C presented
    out_ready = 1'b0;
    drive(1'b1, 32'h44);
    cyc();
    drive(1'b1, 32'h55);
    cyc();
    check("fl_occ2", {62'h0, occupancy}, 64'h2);
    drive(1'b1, 32'h33);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive(1'b0, '0);
    check("fl_ov", {63'h0, out_valid}, 64'h0);
    check("fl_oc", {48'h0, out_ctrl}, 64'h0);
    check("fl_od", {32'h0, out_data}, 64'h0);
    check("fl_occ", {62'h0, occupancy}, 64'h0);
    out_ready = 1'b1;
    repeat (3) begin
      cyc();
      check("fl_noC", {63'h0, out_valid}, 64'h0);
    end

    // Flush with one entry and an accepted in_fire
    out_ready = 1'b0;
    drive(1'b1, 32'h66);
    cyc();
    drive(1'b1, 32'h77);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive(1'b0, '0);
    check("fl1_occ", {62'h0, occupancy}, 64'h0);
    check("fl1_ir", {63'h0, in_ready}, 64'h1);

    // Bubble control
    in_valid = 1'b0;
    in_ctrl  = 16'hFFFF;
    in_data  = 32'hCAFE;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("bub_oc", {48'h0, out_ctrl}, 64'h0);
    end

    // Reset mid-operation drops entries
    drive(1'b1, 32'h88);
    cyc();
    drive(1'b1, 32'h99);
    cyc();
    drive(1'b0, '0);
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    check("mrst_occ", {62'h0, occupancy}, 64'h0);
    check("mrst_ir", {63'h0, in_ready}, 64'h1);
    out_ready = 1'b1;
    cyc();
    check("mrst_ov", {63'h0, out_valid}, 64'h0);

`ifdef PIPE_STAGE_PERF_EN
    out_ready = 1'b0;
    drive(1'b1, 32'hAB);
    cyc();
    drive(1'b0, '0);
    st0 = m_stall;
    bb0 = m_bubble;
    check("perf_st_m", {32'h0, stall_cnt}, {32'h0, m_stall});
    check("perf_bb_m", {32'h0, bubble_cnt}, {32'h0, m_bubble});
    repeat (4) cyc();
    out_ready = 1'b1;
    cyc();
    repeat (3) cyc();
    check("perf_stall", {32'h0, stall_cnt - st0}, 64'd4);
    check("perf_bub", {32'h0, bubble_cnt - bb0}, 64'd3);
`endif

    cyc();
    check("sb_left", 64'(sb.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register for the RV32 core. Successor to the fixed per-stage registers; instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries a wide data payload plus a control bundle, with a valid/ready handshake and a 2-entry skid buffer, so stalls propagate without combinational ready paths.
- Control bits are forced to zero whenever the stage holds no valid entry, so a bubble is a NOP.
- A synchronous flush squashes the stage on branch/jump redirect.

Parameters:
DATA_W, 32, payload width (pc, operands, imm, instr bundle); passed through unmodified
CTRL_W, 16, control bundle width (reg_write, mem_read, mem_write, branch, jump, ...); zeroed when invalid
CNT_W, 32, width of performance counters (used only with PIPE_STAGE_PERF_EN)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
flush  in  1  squash all entries held in the stage
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept; registered, equals ~skid_valid
in_data  in  DATA_W  upstream payload
in_ctrl  in  CTRL_W  upstream control bundle
out_valid  out  1  main entry valid
out_ready  in  1  downstream accepts
out_data  out  DATA_W  main entry payload
out_ctrl  out  CTRL_W  main entry control; '0 when out_valid=0
occupancy  out  2  entries held (0, 1 or 2)

Behaviour:
- Reset and clock: reset rstn, synchronous, active-low; clock clk.
- Storage: main register M (valid, data, ctrl) and skid register S (valid, data, ctrl).
- Handshake:
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - out_valid = M.valid; out_data = M.data; out_ctrl = M.valid ? M.ctrl : '0.
- Reset (rstn=0 at posedge):
  - M and S valid/data/ctrl all cleared to 0, so out_valid=0, out_data=0, out_ctrl=0, occupancy=0, in_ready=1.
  - Any in_fire in the reset cycle is discarded.
  - Reset mid-operation drops all entries.
- States (encoded by occupancy):
  - EMPTY: in_fire -> ONE, M<=in. Otherwise hold.
  - ONE:
    - in_fire & out_fire -> ONE, M<=in.
    - in_fire & ~out_fire -> TWO, S<=in.
    - ~in_fire & out_fire -> EMPTY, M cleared.
    - Neither -> hold.
  - TWO: in_ready=0. out_fire -> ONE, M<=S, S cleared. Otherwise hold.
- Latency and throughput: 1 cycle from in_fire to out_valid in an empty stage; sustained throughput 1 entry/cycle when out_ready stays high.
- Ordering: strict FIFO; S is never presented before M.
- Flush (priority below reset, above all transfers):
  - Next cycle M and S are invalid, their data/ctrl are 0, and occupancy=0.
  - An in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle counts as consumed downstream (downstream must squash it itself).
- Held data: when out_valid=1 and out_ready=0, out_data and out_ctrl are stable until out_fire or flush.
- Unused fields: S.data and S.ctrl are 0 whenever S.valid=0; M.data and M.ctrl are 0 whenever M.valid=0 (deterministic debug view).

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- When defined, two extra output ports are added:
  - stall_cnt [CNT_W]: increments each cycle out_valid & ~out_ready.
  - bubble_cnt [CNT_W]: increments each cycle out_valid=0 after reset.
  - Both saturate at all-ones, clear on reset only (not on flush), and update one cycle after the condition.
- When undefined, the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset held 3 cycles with in_valid=1, in_data=0xDEADBEEF -> out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; no entry is captured.
- Streaming: 8 entries data=0x100..0x107, out_ready=1 every cycle -> outputs appear in order, each 1 cycle after input; in_ready stays 1; occupancy stays 1.
- Backpressure: send A=0x11, then B=0x22 with out_ready=0 -> occupancy=2, in_ready=0, out_data=0x11 held. Raise out_ready -> 0x11 then 0x22 are delivered, and in_ready returns to 1 the cycle after the first out_fire.
- Flush with occupancy=2 and in_valid=1 (C=0x33) -> next cycle out_valid=0, out_ctrl=0, out_data=0, occupancy=0; C is never output.
- Bubble control: in_ctrl=0xFFFF with in_valid=0 for 5 cycles -> out_ctrl=0 throughout.
- With PIPE_STAGE_PERF_EN: out_ready=0 for 4 cycles while valid, then 3 empty cycles -> stall_cnt=4, bubble_cnt=3 more than the pre-test value.
